// File: rtl/axi_rd_pkg.sv
// Shared definitions for the AXI4 read engine: FSM state encoding,
// RRESP codes and the stride-code decode.
package axi_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN
  } rd_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Codes 0..4 give 16..256 bytes; 5..7 give 0 so the address repeats.
  function automatic logic [8:0] stride_bytes(input logic [2:0] code);
    if (code <= 3'd4) stride_bytes = 9'd16 << code;
    else              stride_bytes = 9'd0;
  endfunction

endpackage

// File: rtl/axi_rd_rbuf.sv
// Response buffer: synchronous FIFO of {RID,RDATA,RRESP,RLAST} beats.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   push, wdata    write side (ignored when full)
//   pop            read side (ignored when empty)
//   rdata          head entry (valid when !empty)
//   full, empty    occupancy flags
module axi_rd_rbuf
  import axi_rd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/axi_rd_engine.sv
// AXI4 read master between the LSU and the interconnect. One LSU command
// expands into arnum+1 strided AR bursts, at most MAX_OUTS in flight; R
// beats return to the LSU through a small buffer with RREADY backpressure,
// and axi_lsu_rdone pulses once the whole command has been returned.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   AR*, ARVALID/ARREADY              AR channel (ARREGION tied to 0)
//   R*, RVALID/RREADY                 R channel
//   lsu_axi_ar*, lsu_axi_arvld/arrdy  LSU command
//   axi_lsu_r*, axi_lsu_rvld/rrdy     buffered beats to the LSU
//   axi_lsu_rdone                     command-complete pulse
// Optional feature macro AXI_RD_ERR_CAPTURE_EN adds axi_lsu_err and
// axi_lsu_err_id: sticky capture of the first error/invalid-slot beat.
module axi_rd_engine
  import axi_rd_pkg::*;
#(
  parameter int ID_W       = 4,
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 64,
  parameter int MAX_OUTS   = 8,
  parameter int RBUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ID_W-1:0]   ARID,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [7:0]        ARLEN,
  output logic [2:0]        ARSIZE,
  output logic [1:0]        ARBURST,
  output logic [3:0]        ARREGION,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [ID_W-1:0]   RID,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RLAST,
  input  logic              RVALID,
  output logic              RREADY,
  input  logic              lsu_axi_arvld,
  output logic              lsu_axi_arrdy,
  input  logic [ADDR_W-1:0] lsu_axi_araddr,
  input  logic [7:0]        lsu_axi_arlen,
  input  logic [2:0]        lsu_axi_arsize,
  input  logic [1:0]        lsu_axi_arburst,
  input  logic [2:0]        lsu_axi_arstr,
  input  logic [3:0]        lsu_axi_arnum,
  output logic              axi_lsu_rvld,
  input  logic              lsu_axi_rrdy,
  output logic [ID_W-1:0]   axi_lsu_rid,
  output logic [DATA_W-1:0] axi_lsu_rdata,
  output logic [1:0]        axi_lsu_rresp,
  output logic              axi_lsu_rlast,
`ifdef AXI_RD_ERR_CAPTURE_EN
  output logic              axi_lsu_err,
  output logic [ID_W-1:0]   axi_lsu_err_id,
`endif
  output logic              axi_lsu_rdone
);

  localparam int SLOT_W = $clog2(MAX_OUTS);
  localparam int OW     = $clog2(MAX_OUTS + 1);
  localparam int BW     = ID_W + DATA_W + 3;
  localparam logic [OW-1:0] MAX_CNT = OW'(MAX_OUTS);

  rd_state_e         state;
  logic [SLOT_W-1:0] slot_id;
  logic [SLOT_W-1:0] rslot;
  logic [MAX_OUTS-1:0] vld;
  logic [OW-1:0]     outs_cnt;
  logic [OW-1:0]     outs_nxt;
  logic [3:0]        cnt;
  logic [3:0]        arnum;
  logic [2:0]        arstr;
  logic              cmd_hs;
  logic              ar_hs;
  logic              r_hs;
  logic              retire;
  logic              buf_full;
  logic              buf_empty;
  logic [BW-1:0]     buf_rdata;

  assign ARID          = ID_W'(slot_id);
  assign ARREGION      = '0;
  assign lsu_axi_arrdy = ~rst & (state == ST_IDLE);
  assign RREADY        = ~rst & ~buf_full;

  assign cmd_hs   = lsu_axi_arvld & lsu_axi_arrdy;
  assign ar_hs    = ARVALID & ARREADY;
  assign r_hs     = RVALID & RREADY;
  assign rslot    = RID[SLOT_W-1:0];
  assign retire   = r_hs & RLAST & vld[rslot];
  // Issue and retire in the same cycle cancel out.
  assign outs_nxt = outs_cnt + {{(OW-1){1'b0}}, ar_hs} - {{(OW-1){1'b0}}, retire};

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      ARVALID       <= 1'b0;
      ARADDR        <= '0;
      ARLEN         <= '0;
      ARSIZE        <= '0;
      ARBURST       <= '0;
      slot_id       <= '0;
      vld           <= '0;
      outs_cnt      <= '0;
      cnt           <= '0;
      arnum         <= '0;
      arstr         <= '0;
      axi_lsu_rdone <= 1'b0;
    end else begin
      axi_lsu_rdone <= 1'b0;
      outs_cnt      <= outs_nxt;
      if (retire) vld[rslot] <= 1'b0;
      // Set after clear so a slot reused in the retire cycle stays valid.
      if (ar_hs) begin
        vld[slot_id] <= 1'b1;
        slot_id      <= slot_id + SLOT_W'(1);
      end
      case (state)
        ST_IDLE: begin
          if (cmd_hs) begin
            ARADDR  <= lsu_axi_araddr;
            ARLEN   <= lsu_axi_arlen;
            ARSIZE  <= lsu_axi_arsize;
            ARBURST <= lsu_axi_arburst;
            arstr   <= lsu_axi_arstr;
            arnum   <= lsu_axi_arnum;
            cnt     <= '0;
            ARVALID <= 1'b1;
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // ARADDR doubles as the running burst address.
          if (ar_hs) begin
            ARADDR <= ARADDR + ADDR_W'(stride_bytes(arstr));
            cnt    <= cnt + 4'd1;
            if (cnt == arnum) begin
              ARVALID <= 1'b0;
              state   <= ST_DRAIN;
            end else begin
              ARVALID <= (outs_nxt < MAX_CNT);
            end
          end else if (!ARVALID) begin
            ARVALID <= (outs_nxt < MAX_CNT);
          end
        end
        ST_DRAIN: begin
          if (outs_cnt == '0 && buf_empty) begin
            axi_lsu_rdone <= 1'b1;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  axi_rd_rbuf #(
    .DEPTH(RBUF_DEPTH),
    .W    (BW)
  ) u_rbuf (
    .clk  (clk),
    .rst  (rst),
    .push (r_hs),
    .wdata({RID, RDATA, RRESP, RLAST}),
    .pop  (lsu_axi_rrdy),
    .rdata(buf_rdata),
    .full (buf_full),
    .empty(buf_empty)
  );

  assign axi_lsu_rvld = ~buf_empty;
  assign {axi_lsu_rid, axi_lsu_rdata, axi_lsu_rresp, axi_lsu_rlast} =
    buf_empty ? '0 : buf_rdata;

`ifdef AXI_RD_ERR_CAPTURE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      axi_lsu_err    <= 1'b0;
      axi_lsu_err_id <= '0;
    end else if (cmd_hs) begin
      axi_lsu_err    <= 1'b0;
      axi_lsu_err_id <= '0;
    end else if (r_hs && !axi_lsu_err && (RRESP != RESP_OKAY || !vld[rslot])) begin
      axi_lsu_err    <= 1'b1;
      axi_lsu_err_id <= RID;
    end
  end
`endif

endmodule

// File: tb/tb_axi_rd_engine.sv
module tb_axi_rd_engine;

  localparam int NOUT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  ARID;
  logic [9:0]  ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic [3:0]  ARREGION;
  logic        ARVALID;
  logic        ARREADY = 1'b0;
  logic [3:0]  RID = '0;
  logic [63:0] RDATA = '0;
  logic [1:0]  RRESP = '0;
  logic        RLAST = 1'b0;
  logic        RVALID = 1'b0;
  logic        RREADY;
  logic        lsu_axi_arvld = 1'b0;
  logic        lsu_axi_arrdy;
  logic [9:0]  lsu_axi_araddr = '0;
  logic [7:0]  lsu_axi_arlen = '0;
  logic [2:0]  lsu_axi_arsize = '0;
  logic [1:0]  lsu_axi_arburst = '0;
  logic [2:0]  lsu_axi_arstr = '0;
  logic [3:0]  lsu_axi_arnum = '0;
  logic        axi_lsu_rvld;
  logic        lsu_axi_rrdy = 1'b0;
  logic [3:0]  axi_lsu_rid;
  logic [63:0] axi_lsu_rdata;
  logic [1:0]  axi_lsu_rresp;
  logic        axi_lsu_rlast;
  logic        axi_lsu_rdone;
`ifdef AXI_RD_ERR_CAPTURE_EN
  logic        axi_lsu_err;
  logic [3:0]  axi_lsu_err_id;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int exp_id = 0;

  typedef struct {
    int          id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  always #5 clk = ~clk;

  axi_rd_engine dut (
    .clk(clk), .rst(rst),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARREGION(ARREGION), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
    .RREADY(RREADY),
    .lsu_axi_arvld(lsu_axi_arvld), .lsu_axi_arrdy(lsu_axi_arrdy),
    .lsu_axi_araddr(lsu_axi_araddr), .lsu_axi_arlen(lsu_axi_arlen),
    .lsu_axi_arsize(lsu_axi_arsize), .lsu_axi_arburst(lsu_axi_arburst),
    .lsu_axi_arstr(lsu_axi_arstr), .lsu_axi_arnum(lsu_axi_arnum),
    .axi_lsu_rvld(axi_lsu_rvld), .lsu_axi_rrdy(lsu_axi_rrdy),
    .axi_lsu_rid(axi_lsu_rid), .axi_lsu_rdata(axi_lsu_rdata),
    .axi_lsu_rresp(axi_lsu_rresp), .axi_lsu_rlast(axi_lsu_rlast),
`ifdef AXI_RD_ERR_CAPTURE_EN
    .axi_lsu_err(axi_lsu_err), .axi_lsu_err_id(axi_lsu_err_id),
`endif
    .axi_lsu_rdone(axi_lsu_rdone)
  );

  // Reference stride: 16 << code for codes 0..4, otherwise no advance.
  function automatic int ref_stride(input int code);
    return (code <= 4) ? (16 * (1 << code)) : 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [9:0] a, input logic [2:0] s,
                          input logic [3:0] n, input logic [7:0] l);
    int t;
    t = 0;
    while (!lsu_axi_arrdy && t < 50) begin
      step();
      t++;
    end
    n_chk++;
    if (lsu_axi_arrdy !== 1'b1) begin
      n_fail++;
      $display("FAIL cmd_ready: arrdy=%0b required 1", lsu_axi_arrdy);
    end
    lsu_axi_arvld = 1'b1; lsu_axi_araddr = a; lsu_axi_arstr = s;
    lsu_axi_arnum = n; lsu_axi_arlen = l; lsu_axi_arsize = 3'd3; lsu_axi_arburst = 2'd1;
    step();
    lsu_axi_arvld = 1'b0;
  endtask

  task automatic send_beat(input int id, input logic [63:0] d,
                           input logic [1:0] resp, input logic last);
    int t;
    RVALID = 1'b1; RID = id[3:0]; RDATA = d; RRESP = resp; RLAST = last;
    t = 0;
    while (!RREADY && t < 50) begin
      step();
      t++;
    end
    n_chk++;
    if (RREADY !== 1'b1) begin
      n_fail++;
      $display("FAIL beat_ready: RREADY=%0b required 1", RREADY);
    end
    step();
    RVALID = 1'b0; RLAST = 1'b0;
  endtask

  task automatic wait_done();
    int seen;
    seen = 0;
    lsu_axi_rrdy = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (axi_lsu_rdone) seen++;
      step();
    end
    n_chk++;
    if (seen != 1) begin
      n_fail++;
      $display("FAIL rdone_count: got %0d pulses required 1", seen);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_chk++;
    if (lsu_axi_arrdy !== 1'b0 || RREADY !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rdy_in_rst: arrdy=%0b rready=%0b required 0 0", lsu_axi_arrdy, RREADY);
    end
    n_chk++;
    if (ARVALID !== 1'b0 || ARID !== 4'd0 || ARADDR !== 10'd0 || ARLEN !== 8'd0 ||
        axi_lsu_rvld !== 1'b0 || axi_lsu_rdata !== 64'd0 || axi_lsu_rdone !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: arvalid=%0b arid=%0h araddr=%0h rvld=%0b rdone=%0b required all 0",
               ARVALID, ARID, ARADDR, axi_lsu_rvld, axi_lsu_rdone);
    end
    rst = 1'b0;
    #1;
    n_chk++;
    if (lsu_axi_arrdy !== 1'b1 || RREADY !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_rdy_after: arrdy=%0b rready=%0b required 1 1", lsu_axi_arrdy, RREADY);
    end
    exp_id = 0;
  endtask

  task automatic test_single();
    logic [63:0] d;
    int seen;
    d = {$urandom, $urandom};
    ARREADY = 1'b1;
    send_cmd(10'h040, 3'd0, 4'd0, 8'd0);
    n_chk++;
    if (ARVALID !== 1'b1 || ARADDR !== 10'h040 || ARID !== exp_id[3:0]) begin
      n_fail++;
      $display("FAIL single_ar: valid=%0b addr=%0h id=%0h required 1 40 %0h", ARVALID, ARADDR, ARID, exp_id);
    end
    step();
    exp_id = (exp_id + 1) % NOUT;
    n_chk++;
    if (ARVALID !== 1'b0) begin
      n_fail++;
      $display("FAIL single_ar_once: valid=%0b required 0", ARVALID);
    end
    lsu_axi_rrdy = 1'b0;
    send_beat(0, d, 2'b00, 1'b1);
    n_chk++;
    if (axi_lsu_rvld !== 1'b1 || axi_lsu_rdata !== d || axi_lsu_rlast !== 1'b1 || axi_lsu_rid !== 4'd0) begin
      n_fail++;
      $display("FAIL single_beat: rvld=%0b data=%0h last=%0b required 1 %0h 1", axi_lsu_rvld, axi_lsu_rdata, axi_lsu_rlast, d);
    end
    seen = 0;
    lsu_axi_rrdy = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (axi_lsu_rdone) seen++;
      step();
    end
    n_chk++;
    if (seen != 1) begin
      n_fail++;
      $display("FAIL single_rdone: got %0d pulses required 1", seen);
    end
  endtask

  task automatic test_strided();
    int ids[$];
    int ea;
    ARREADY = 1'b1;
    send_cmd(10'h3C0, 3'd1, 4'd3, 8'd0);
    for (int k = 0; k < 4; k++) begin
      ea = (32'h3C0 + k * ref_stride(1)) % 1024;
      n_chk++;
      if (ARVALID !== 1'b1 || ARADDR !== ea[9:0] || ARID !== exp_id[3:0]) begin
        n_fail++;
        $display("FAIL strided_ar%0d: valid=%0b addr=%0h id=%0h required 1 %0h %0h", k, ARVALID, ARADDR, ARID, ea, exp_id);
      end
      ids.push_back(exp_id);
      exp_id = (exp_id + 1) % NOUT;
      step();
    end
    n_chk++;
    if (ARVALID !== 1'b0) begin
      n_fail++;
      $display("FAIL strided_stop: valid=%0b required 0", ARVALID);
    end
    lsu_axi_rrdy = 1'b1;
    foreach (ids[i]) send_beat(ids[i], 64'(i), 2'b00, 1'b1);
    wait_done();
  endtask

  task automatic test_outs_limit();
    int hs;
    int first;
    ARREADY = 1'b1;
    lsu_axi_rrdy = 1'b1;
    first = exp_id;
    send_cmd(10'h100, 3'd0, 4'd15, 8'd0);
    hs = 0;
    for (int c = 0; c < 20; c++) begin
      if (ARVALID && ARREADY) begin
        hs++;
        exp_id = (exp_id + 1) % NOUT;
      end
      step();
    end
    n_chk++;
    if (hs != NOUT || ARVALID !== 1'b0) begin
      n_fail++;
      $display("FAIL outs_limit: handshakes=%0d valid=%0b required %0d 0", hs, ARVALID, NOUT);
    end
    send_beat(first, 64'h55, 2'b00, 1'b1);
    n_chk++;
    if (ARVALID !== 1'b1 || ARID !== exp_id[3:0] || ARADDR !== 10'h180) begin
      n_fail++;
      $display("FAIL outs_ninth: valid=%0b id=%0h addr=%0h required 1 %0h 180", ARVALID, ARID, ARADDR, exp_id);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_id = 0;
  endtask

  task automatic test_backpressure();
    logic [63:0] dat [6];
    int id, pi, po, done;
    logic r_acc;
    foreach (dat[i]) dat[i] = {$urandom, $urandom};
    ARREADY = 1'b1;
    lsu_axi_rrdy = 1'b0;
    send_cmd(10'h000, 3'd0, 4'd0, 8'd5);
    id = exp_id;
    exp_id = (exp_id + 1) % NOUT;
    pi = 0; po = 0; done = 0;
    for (int c = 0; c < 40; c++) begin
      if (c == 15) begin
        n_chk++;
        if (pi != 4 || RREADY !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_full: accepted=%0d rready=%0b required 4 0", pi, RREADY);
        end
        lsu_axi_rrdy = 1'b1;
      end
      if (pi < 6) begin
        RVALID = 1'b1; RID = id[3:0]; RDATA = dat[pi]; RRESP = 2'b00; RLAST = (pi == 5);
      end else begin
        RVALID = 1'b0; RLAST = 1'b0;
      end
      r_acc = RVALID && RREADY;
      if (axi_lsu_rvld && lsu_axi_rrdy) begin
        n_chk++;
        if (po >= 6 || axi_lsu_rdata !== dat[po]) begin
          n_fail++;
          $display("FAIL bp_order: pop %0d data=%0h required %0h", po, axi_lsu_rdata, (po < 6) ? dat[po] : 64'd0);
        end
        po++;
      end
      if (axi_lsu_rdone) done++;
      step();
      if (r_acc) pi++;
    end
    RVALID = 1'b0;
    n_chk++;
    if (po != 6 || done != 1) begin
      n_fail++;
      $display("FAIL bp_total: pops=%0d rdone=%0d required 6 1", po, done);
    end
  endtask

  task automatic test_arready_stall();
    logic [9:0] a;
    int id;
    a = 10'($urandom_range(0, 1023));
    ARREADY = 1'b0;
    send_cmd(a, 3'd2, 4'd0, 8'd0);
    for (int c = 0; c < 5; c++) begin
      n_chk++;
      if (ARVALID !== 1'b1 || ARADDR !== a) begin
        n_fail++;
        $display("FAIL stall_hold%0d: valid=%0b addr=%0h required 1 %0h", c, ARVALID, ARADDR, a);
      end
      step();
    end
    ARREADY = 1'b1;
    step();
    id = exp_id;
    exp_id = (exp_id + 1) % NOUT;
    n_chk++;
    if (ARVALID !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_issue: valid=%0b required 0", ARVALID);
    end
    lsu_axi_rrdy = 1'b1;
    send_beat(id, 64'h1234, 2'b00, 1'b1);
    wait_done();
  endtask

  task automatic test_reset_mid_drain();
    ARREADY = 1'b1;
    lsu_axi_rrdy = 1'b0;
    send_cmd(10'h200, 3'd2, 4'd2, 8'd0);
    step(); step(); step();
    send_beat(exp_id, 64'hABCD, 2'b00, 1'b0);
    n_chk++;
    if (axi_lsu_rvld !== 1'b1 || lsu_axi_arrdy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_pre: rvld=%0b arrdy=%0b required 1 0", axi_lsu_rvld, lsu_axi_arrdy);
    end
    rst = 1'b1;
    step();
    n_chk++;
    if (ARVALID !== 1'b0 || ARID !== 4'd0 || ARADDR !== 10'd0 || axi_lsu_rvld !== 1'b0 ||
        axi_lsu_rdata !== 64'd0 || axi_lsu_rdone !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: valid=%0b id=%0h addr=%0h rvld=%0b data=%0h required 0 0 0 0 0",
               ARVALID, ARID, ARADDR, axi_lsu_rvld, axi_lsu_rdata);
    end
    rst = 1'b0;
    #1;
    exp_id = 0;
    n_chk++;
    if (lsu_axi_arrdy !== 1'b1 || RREADY !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_ready: arrdy=%0b rready=%0b required 1 1", lsu_axi_arrdy, RREADY);
    end
`ifdef AXI_RD_ERR_CAPTURE_EN
    n_chk++;
    if (axi_lsu_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_reset: err=%0b required 0", axi_lsu_err);
    end
`endif
    send_cmd(10'h155, 3'd0, 4'd0, 8'd0);
    n_chk++;
    if (ARVALID !== 1'b1 || ARADDR !== 10'h155 || ARID !== 4'd0) begin
      n_fail++;
      $display("FAIL mid_newcmd: valid=%0b addr=%0h id=%0h required 1 155 0", ARVALID, ARADDR, ARID);
    end
    step();
    exp_id = 1;
    lsu_axi_rrdy = 1'b1;
    send_beat(0, 64'h77, 2'b10, 1'b1);
`ifdef AXI_RD_ERR_CAPTURE_EN
    n_chk++;
    if (axi_lsu_err !== 1'b1 || axi_lsu_err_id !== 4'd0) begin
      n_fail++;
      $display("FAIL err_capture: err=%0b id=%0h required 1 0", axi_lsu_err, axi_lsu_err_id);
    end
`endif
    n_chk++;
    if (axi_lsu_rresp !== 2'b10) begin
      n_fail++;
      $display("FAIL mid_rresp: rresp=%0h required 2", axi_lsu_rresp);
    end
    wait_done();
  endtask

  task automatic test_random();
    beat_t sq[$];
    beat_t lq[$];
    beat_t b;
    int base, str, num, len, k, ea, done;
    logic ar_acc, r_acc;
    for (int cmd = 0; cmd < 8; cmd++) begin
      base = $urandom_range(0, 1023);
      str  = $urandom_range(0, 7);
      num  = $urandom_range(0, 9);
      len  = $urandom_range(0, 2);
      RVALID = 1'b0;
      send_cmd(base[9:0], str[2:0], num[3:0], len[7:0]);
      k = 0; done = 0;
      for (int c = 0; c < 800 && done == 0; c++) begin
        ARREADY = ($urandom_range(0, 3) != 0);
        lsu_axi_rrdy = ($urandom_range(0, 3) != 0);
        if (!RVALID && sq.size() > 0 && $urandom_range(0, 2) != 0) begin
          RVALID = 1'b1; RID = sq[0].id[3:0]; RDATA = sq[0].data;
          RRESP = sq[0].resp; RLAST = sq[0].last;
        end
        ar_acc = ARVALID && ARREADY;
        r_acc  = RVALID && RREADY;
        if (ar_acc) begin
          ea = (base + k * ref_stride(str)) % 1024;
          n_chk++;
          if (k > num || ARADDR !== ea[9:0] || ARID !== exp_id[3:0] || ARLEN !== len[7:0]) begin
            n_fail++;
            $display("FAIL rand_ar: cmd %0d burst %0d addr=%0h id=%0h len=%0d required %0h %0h %0d (max burst %0d)",
                     cmd, k, ARADDR, ARID, ARLEN, ea, exp_id, len, num);
          end
          for (int j = 0; j <= len; j++) begin
            b.id = exp_id; b.data = {$urandom, $urandom};
            b.resp = 2'($urandom_range(0, 3)); b.last = (j == len);
            sq.push_back(b);
          end
          k++;
          exp_id = (exp_id + 1) % NOUT;
        end
        if (axi_lsu_rvld && lsu_axi_rrdy) begin
          n_chk++;
          if (lq.size() == 0) begin
            n_fail++;
            $display("FAIL rand_pop: unexpected beat data=%0h", axi_lsu_rdata);
          end else begin
            b = lq.pop_front();
            if (axi_lsu_rdata !== b.data || axi_lsu_rid !== b.id[3:0] ||
                axi_lsu_rresp !== b.resp || axi_lsu_rlast !== b.last) begin
              n_fail++;
              $display("FAIL rand_pop: data=%0h id=%0h resp=%0h last=%0b required %0h %0h %0h %0b",
                       axi_lsu_rdata, axi_lsu_rid, axi_lsu_rresp, axi_lsu_rlast, b.data, b.id, b.resp, b.last);
            end
          end
        end
        if (axi_lsu_rdone) begin
          done = 1;
          n_chk++;
          if (k != num + 1 || lq.size() != 0 || sq.size() != 0 || RVALID) begin
            n_fail++;
            $display("FAIL rand_done: bursts=%0d pending=%0d/%0d required %0d 0/0", k, lq.size(), sq.size(), num + 1);
          end
        end
        step();
        if (r_acc) begin
          lq.push_back(sq.pop_front());
          RVALID = 1'b0; RLAST = 1'b0;
        end
      end
      n_chk++;
      if (done != 1) begin
        n_fail++;
        $display("FAIL rand_timeout: cmd %0d rdone=%0d required 1", cmd, done);
      end
      RVALID = 1'b0;
      sq.delete();
      lq.delete();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_strided();
    test_outs_limit();
    test_backpressure();
    test_arready_stall();
    test_reset_mid_drain();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
